// File: rtl/ser_frame_tx_pkg.sv
// Shared types and line levels for the framed serial transmitter.
package serdes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/ser_frame_tx_if.sv
// Byte valid/ready handshake into the framed serial transmitter.
interface ser_frame_tx_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/ser_frame_tx_fifo.sv
// First-word-fall-through byte FIFO; full/empty derive from the registered level.
module sync_byte_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_W-1:0]             wdata,
  input  logic                          pop,
  output logic [DATA_W-1:0]             rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is not reset; the pointers and level alone define the flushed state.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ser_frame_tx.sv
// Framed serial transmitter: start, DATA_W bits LSB first, optional even parity, stop.
// Build option: define SER_FRAME_PARITY_EN to insert the parity bit.
module ser_frame_tx
  import serdes_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_DIV    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  ser_frame_tx_if.slave               in_if,
  output logic                        ser_out,
  output logic                        ser_busy,
  output logic                        frame_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(BIT_DIV - 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
  localparam logic          DONE_ON_ENTRY = (BIT_DIV == 1);

  tx_state_t         state;
  logic [CW-1:0]     bit_cnt;
  logic [IW-1:0]     bit_idx;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic              pop;
  logic              bit_last;
`ifdef SER_FRAME_PARITY_EN
  logic              parity;
`endif

  assign in_if.in_ready = !full;
  assign bit_last       = (bit_cnt == CNT_LAST);
  assign pop            = !empty && ((state == IDLE) || (state == STOP && bit_last));

  sync_byte_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_if.in_valid),
    .wdata (in_if.in_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ser_out    <= IDLE_LEVEL;
      ser_busy   <= 1'b0;
      frame_done <= 1'b0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
`ifdef SER_FRAME_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            shift    <= head;
            state    <= START;
            ser_out  <= START_BIT;
            ser_busy <= 1'b1;
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (bit_last) begin
            state   <= DATA;
            ser_out <= shift[0];
            bit_cnt <= '0;
            bit_idx <= '0;
`ifdef SER_FRAME_PARITY_EN
            parity  <= shift[0];
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
`ifdef SER_FRAME_PARITY_EN
              state   <= PARITY;
              ser_out <= parity;
`else
              state      <= STOP;
              ser_out    <= STOP_BIT;
              frame_done <= DONE_ON_ENTRY;
`endif
            end else begin
              // Shift ahead so shift[1] is always the next bit to send.
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              ser_out <= shift[1];
`ifdef SER_FRAME_PARITY_EN
              parity  <= parity ^ shift[1];
`endif
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_last) begin
            state      <= STOP;
            ser_out    <= STOP_BIT;
            frame_done <= DONE_ON_ENTRY;
            bit_cnt    <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (!empty) begin
              shift   <= head;
              state   <= START;
              ser_out <= START_BIT;
            end else begin
              state    <= IDLE;
              ser_busy <= 1'b0;
            end
          end else begin
            // Registered pulse: raise it one clk early so it lands on the final stop clk.
            bit_cnt    <= bit_cnt + 1'b1;
            frame_done <= (bit_cnt == CNT_PRE);
          end
        end
        default: begin
          state    <= IDLE;
          ser_out  <= IDLE_LEVEL;
          ser_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_frame_tx.sv
// Directed bench for ser_frame_tx: line decoder plus per-scenario tasks with inline checks.
module tb_ser_frame_tx;

  localparam int BD = 4;
`ifdef SER_FRAME_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * BD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ser_out, ser_busy, frame_done;
  logic [2:0] fifo_level;

  always #5 clk = ~clk;

  ser_frame_tx_if #(.DATA_W(8)) bus ();

  ser_frame_tx #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .BIT_DIV    (BD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_if      (bus.slave),
    .ser_out    (ser_out),
    .ser_busy   (ser_busy),
    .frame_done (frame_done),
    .fifo_level (fifo_level)
  );

  int nerr = 0;
  int nchk = 0;

  // Line decoder state, sampled on falling edges
  logic [10:0] rx_q [$];
  int          st_q [$];
  logic [10:0] bits;
  bit          rx_active = 1'b0;
  int          ph = 0;
  int          cyc = 0;
  int          st_cyc = 0;
  int          fd_cnt = 0;
  int          fd_bad = 0;
  int          rdy_bad = 0;
  int          max_level = 0;

  initial begin
    bits = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        rx_active = 1'b0;
      end else begin
        if (frame_done === 1'b1) begin
          fd_cnt++;
          if (!(rx_active && ph == FL - 1)) fd_bad++;
        end
        if (bus.in_ready !== (fifo_level != 3'd4)) rdy_bad++;
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        if (!rx_active && ser_out === 1'b0) begin
          rx_active = 1'b1;
          ph = 0;
          st_cyc = cyc;
          bits = '0;
        end
        if (rx_active) begin
          if (ph % BD == 1) bits[ph / BD] = ser_out;
          if (ph == FL - 1) begin
            rx_q.push_back(bits);
            st_q.push_back(st_cyc);
            rx_active = 1'b0;
          end else begin
            ph++;
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    int n;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    nchk++;
    if (n >= 2000) begin
      nerr++;
      $display("FAIL push_timeout: in_ready=%b required 1 for byte %h", bus.in_ready, b);
    end
    @(negedge clk);
  endtask

  task automatic release_bus();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int lim);
    int t;
    t = 0;
    while (rx_q.size() < n && t < lim) begin
      @(negedge clk);
      t++;
    end
    nchk++;
    if (rx_q.size() < n) begin
      nerr++;
      $display("FAIL frame_timeout: got %0d frames required %0d", rx_q.size(), n);
    end
  endtask

  task automatic clear_rx();
    rx_q.delete();
    st_q.delete();
  endtask

  task automatic check_frame(input int k, input logic [7:0] d, input logic p);
    logic [10:0] f;
    f = rx_q[k];
    nchk++;
    if (f[8:1] !== d) begin
      nerr++;
      $display("FAIL frame%0d_data: got %h required %h", k, f[8:1], d);
    end
    nchk++;
    if (f[0] !== 1'b0 || f[NB-1] !== 1'b1) begin
      nerr++;
      $display("FAIL frame%0d_framing: start=%b stop=%b required 0/1", k, f[0], f[NB-1]);
    end
`ifdef SER_FRAME_PARITY_EN
    nchk++;
    if (f[9] !== p) begin
      nerr++;
      $display("FAIL frame%0d_parity: got %b required %b", k, f[9], p);
    end
`else
    if (p === 1'bx) $display("unexpected parity argument");
`endif
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      nchk++;
      if (ser_out !== 1'b1 || ser_busy !== 1'b0 || bus.in_ready !== 1'b1 ||
          fifo_level !== 3'd0 || frame_done !== 1'b0) begin
        nerr++;
        $display("FAIL reset_idle cyc%0d: ser_out=%b busy=%b ready=%b level=%0d done=%b required 1/0/1/0/0",
                 i, ser_out, ser_busy, bus.in_ready, fifo_level, frame_done);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [10:0] seq;
    int fd0;
`ifdef SER_FRAME_PARITY_EN
    seq = 11'b1_0_10100101_0;
`else
    seq = 11'b0_1_10100101_0;
`endif
    clear_rx();
    fd0 = fd_cnt;
    push(8'hA5);
    release_bus();
    nchk++;
    if (ser_out !== 1'b1) begin
      nerr++;
      $display("FAIL latency: ser_out=%b one clk after accept, required 1", ser_out);
    end
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      nchk++;
      if (ser_out !== seq[i / BD] || ser_busy !== 1'b1 || frame_done !== (i == FL - 1)) begin
        nerr++;
        $display("FAIL a5_wave cyc%0d: ser_out=%b busy=%b done=%b required %b/1/%b",
                 i, ser_out, ser_busy, frame_done, seq[i / BD], (i == FL - 1));
      end
    end
    @(negedge clk);
    nchk++;
    if (ser_out !== 1'b1 || ser_busy !== 1'b0) begin
      nerr++;
      $display("FAIL a5_after: ser_out=%b busy=%b required 1/0", ser_out, ser_busy);
    end
    nchk++;
    if (fd_cnt - fd0 !== 1) begin
      nerr++;
      $display("FAIL a5_done_count: got %0d required 1", fd_cnt - fd0);
    end
  endtask

  task automatic test_back_to_back();
    int fd0;
    clear_rx();
    fd0 = fd_cnt;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    release_bus();
    wait_frames(3, 3 * FL + 50);
    repeat (2) @(negedge clk);
    if (rx_q.size() >= 3) begin
      check_frame(0, 8'h00, 1'b0);
      check_frame(1, 8'hFF, 1'b0);
      check_frame(2, 8'h3C, 1'b0);
      for (int k = 0; k < 2; k++) begin
        nchk++;
        if (st_q[k+1] - st_q[k] !== FL) begin
          nerr++;
          $display("FAIL b2b_gap%0d: spacing %0d required %0d", k, st_q[k+1] - st_q[k], FL);
        end
      end
    end
    nchk++;
    if (fd_cnt - fd0 !== 3) begin
      nerr++;
      $display("FAIL b2b_done_count: got %0d required 3", fd_cnt - fd0);
    end
    nchk++;
    if (fd_bad !== 0) begin
      nerr++;
      $display("FAIL done_position: %0d misplaced pulses required 0", fd_bad);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d [6];
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    clear_rx();
    max_level = 0;
    rdy_bad = 0;
    for (int i = 0; i < 6; i++) push(d[i]);
    release_bus();
    wait_frames(6, 6 * FL + 100);
    nchk++;
    if (max_level !== 4) begin
      nerr++;
      $display("FAIL bp_max_level: got %0d required 4", max_level);
    end
    nchk++;
    if (rdy_bad !== 0) begin
      nerr++;
      $display("FAIL bp_ready: %0d cycles with in_ready != (level<4), required 0", rdy_bad);
    end
    nchk++;
    if (rx_q.size() !== 6) begin
      nerr++;
      $display("FAIL bp_count: got %0d frames required 6", rx_q.size());
    end
    if (rx_q.size() >= 6) begin
      for (int i = 0; i < 6; i++) check_frame(i, d[i], ^d[i]);
    end
  endtask

  task automatic test_reset_mid();
    clear_rx();
    push(8'h81);
    push(8'h42);
    push(8'h24);
    release_bus();
    repeat (10) @(negedge clk);
    nchk++;
    if (ser_out !== 1'b0 || ser_busy !== 1'b1 || fifo_level !== 3'd2) begin
      nerr++;
      $display("FAIL mid_before: ser_out=%b busy=%b level=%0d required 0/1/2",
               ser_out, ser_busy, fifo_level);
    end
    #2 reset = 1'b1;
    #1;
    nchk++;
    if (ser_out !== 1'b1 || fifo_level !== 3'd0 || ser_busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL mid_reset: ser_out=%b level=%0d busy=%b ready=%b required 1/0/0/1",
               ser_out, fifo_level, ser_busy, bus.in_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_rx();
    push(8'h5A);
    release_bus();
    wait_frames(1, FL + 20);
    repeat (2 * FL) @(negedge clk);
    nchk++;
    if (rx_q.size() !== 1) begin
      nerr++;
      $display("FAIL mid_after_count: got %0d frames required 1", rx_q.size());
    end
    if (rx_q.size() >= 1) check_frame(0, 8'h5A, 1'b0);
  endtask

`ifdef SER_FRAME_PARITY_EN
  task automatic test_parity();
    clear_rx();
    push(8'h01);
    push(8'h03);
    release_bus();
    wait_frames(2, 2 * FL + 50);
    if (rx_q.size() >= 2) begin
      check_frame(0, 8'h01, 1'b1);
      check_frame(1, 8'h03, 1'b0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef SER_FRAME_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
